fb_sram_arbiter: RTL and testbench

FB_SRAM_ARBITER -- requirements
Module: fb_sram_arbiter

---
 rtl/fb_sram_arbiter_if.sv | 34 +++
 rtl/fb_sram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fb_sram_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fb_sram_arbiter_if.sv
`timescale 1ns/1ps
// Client-side request/ack signals and SRAM control strobes of the frame-buffer arbiter.
// The bidirectional SRAM data bus stays a plain top-level inout.
interface fb_sram_arbiter_if;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 16;

  logic          MODE;
  logic          FRAME_WR;
  logic          FRAME_RD;
  logic          WR_REQ;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          WR_ACK;
  logic          RD_REQ;
  logic [AW-1:0] RD_ADDR;
  logic          RD_ACK;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic [SW-1:0] SRAM_ADDR;
  logic          nSRAM_WE;
  logic          nSRAM_OE;

  modport slave (
    input  MODE, FRAME_WR, FRAME_RD, WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
    output WR_ACK, RD_ACK, RD_DATA, RD_VALID, SRAM_ADDR, nSRAM_WE, nSRAM_OE
  );

  modport master (
    output MODE, FRAME_WR, FRAME_RD, WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR,
    input  WR_ACK, RD_ACK, RD_DATA, RD_VALID, SRAM_ADDR, nSRAM_WE, nSRAM_OE
  );
endinterface

// File: rtl/fb_sram_arbiter.sv
`timescale 1ns/1ps
// Arbitrates a capture-side writer and a video-side reader onto one asynchronous SRAM,
// with read priority, write starvation override and triple-buffer bank rotation.
module fb_sram_arbiter #(
  parameter int unsigned RD_CYCLES    = 2,
  parameter int unsigned WR_CYCLES    = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             CLK_40M,
  input  logic             nRESET,
  fb_sram_arbiter_if.slave bus,
  inout  wire  [15:0]      SRAM_DATA
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 3;
  localparam int unsigned WW = 4;
  localparam int unsigned BW = 2;

  typedef enum logic [2:0] {IDLE, TURN, WSETUP, WRITE, READ} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_t           op_q, op_d;
  op_t           prev_q, prev_d;
  op_t           pend_q, pend_d;
  logic [WW-1:0] wr_wait_q, wr_wait_d;
  logic [BW-1:0] wr_buf_q, wr_buf_d;
  logic [BW-1:0] rd_buf_q, rd_buf_d;
  logic [SW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_data_q, lat_data_d;
  logic [SW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          data_oe_q, data_oe_d;
  logic          nwe_q, nwe_d;
  logic          noe_q, noe_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          wr_last, rd_last, leave, dec, rd_ok, wr_ok;
  logic [BW-1:0] wr_bank, rd_bank;

  // Next state, arbitration and registered-output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    prev_d      = prev_q;
    pend_d      = OP_NONE;
    wr_wait_d   = wr_wait_q;
    wr_buf_d    = wr_buf_q;
    rd_buf_d    = rd_buf_q;
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    sram_addr_d = sram_addr_q;
    wdata_d     = wdata_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    wr_last = (state_q == WRITE) && (cnt_q == CW'(WR_CYCLES - 1));
    rd_last = (state_q == READ)  && (cnt_q == CW'(RD_CYCLES - 1));
    leave   = (state_q == IDLE) || wr_last || rd_last;
    wr_bank = bus.MODE ? wr_buf_q : 2'b00;
    rd_bank = bus.MODE ? rd_buf_q : 2'b00;
    // A request whose ACK is showing this cycle is still the old one
    rd_ok   = bus.RD_REQ && !rd_ack_q;
    wr_ok   = bus.WR_REQ && !wr_ack_q;

    case (state_q)
      IDLE: ;
      TURN: begin
        state_d     = (op_q == OP_WR) ? WSETUP : READ;
        cnt_d       = '0;
        sram_addr_d = lat_addr_q;
        wdata_d     = lat_data_q;
      end
      WSETUP: begin
        state_d = WRITE;
        cnt_d   = '0;
      end
      WRITE: if (!wr_last) cnt_d = cnt_q + CW'(1);
      READ:  if (!rd_last) cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase

    if (leave) begin
      if (pend_q == OP_NONE) begin
        state_d = IDLE;
      end else begin
        op_d   = pend_q;
        prev_d = pend_q;
        cnt_d  = '0;
        if (prev_q != OP_NONE && prev_q != pend_q) begin
          state_d = TURN;
        end else begin
          state_d     = (pend_q == OP_WR) ? WSETUP : READ;
          sram_addr_d = lat_addr_q;
          wdata_d     = lat_data_q;
        end
      end
    end

    if (rd_last) begin
      rd_data_d  = SRAM_DATA;
      rd_valid_d = 1'b1;
    end

    // Grant in IDLE cycles and in the last strobe cycle of an access
    dec = (state_d == IDLE) ||
          (state_d == WRITE && cnt_d == CW'(WR_CYCLES - 1)) ||
          (state_d == READ  && cnt_d == CW'(RD_CYCLES - 1));
    if (dec) begin
      if (wr_ok && (!rd_ok || wr_wait_q >= WW'(STARVE_LIMIT))) begin
        wr_ack_d   = 1'b1;
        pend_d     = OP_WR;
        lat_addr_d = {wr_bank, bus.WR_ADDR};
        lat_data_d = bus.WR_DATA;
      end else if (rd_ok) begin
        rd_ack_d   = 1'b1;
        pend_d     = OP_RD;
        lat_addr_d = {rd_bank, bus.RD_ADDR};
      end
    end

    if (!bus.WR_REQ || wr_ack_q) begin
      wr_wait_d = '0;
    end else if (wr_wait_q < WW'(STARVE_LIMIT)) begin
      wr_wait_d = wr_wait_q + WW'(1);
    end

    // Read bank trails the pre-increment write bank
    if (bus.FRAME_WR) wr_buf_d = wr_buf_q + BW'(1);
    if (bus.FRAME_RD) rd_buf_d = wr_buf_q - BW'(1);

    nwe_d     = (state_d != WRITE);
    noe_d     = (state_d != READ);
    data_oe_d = (state_d == WSETUP) || (state_d == WRITE);
  end

  // State and output registers
  always_ff @(posedge CLK_40M) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NONE;
      prev_q      <= OP_NONE;
      pend_q      <= OP_NONE;
      wr_wait_q   <= '0;
      wr_buf_q    <= 2'd0;
      rd_buf_q    <= 2'd3;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      sram_addr_q <= '0;
      wdata_q     <= '0;
      data_oe_q   <= 1'b0;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      wr_wait_q   <= wr_wait_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      sram_addr_q <= sram_addr_d;
      wdata_q     <= wdata_d;
      data_oe_q   <= data_oe_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign SRAM_DATA     = data_oe_q ? wdata_q : {DW{1'bz}};
  assign bus.WR_ACK    = wr_ack_q;
  assign bus.RD_ACK    = rd_ack_q;
  assign bus.RD_DATA   = rd_data_q;
  assign bus.RD_VALID  = rd_valid_q;
  assign bus.SRAM_ADDR = sram_addr_q;
  assign bus.nSRAM_WE  = nwe_q;
  assign bus.nSRAM_OE  = noe_q;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for fb_sram_arbiter: strobe timing, arbitration, starvation and bank rotation.
module tb_fb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rd_model;
  wire  [15:0] sram_data;
  int          checks = 0;
  int          errors = 0;

  fb_sram_arbiter_if bus();

  fb_sram_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2), .STARVE_LIMIT(8)) dut (
    .CLK_40M  (clk),
    .nRESET   (rst_n),
    .bus      (bus),
    .SRAM_DATA(sram_data)
  );

  always #5 clk = ~clk;

  // SRAM model answers whenever output enable is asserted
  assign sram_data = (!bus.nSRAM_OE) ? rd_model : 16'hzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {29'd0, bus.nSRAM_WE, bus.nSRAM_OE, dut.data_oe_q};
  endfunction

  task automatic do_write(input string tag, input logic [13:0] a, input logic [15:0] d,
                          input bit turn, input logic [15:0] exp_addr);
    bus.WR_REQ = 1'b1; bus.WR_ADDR = a; bus.WR_DATA = d;
    tick();
    chk({tag, " ack"}, 32'(bus.WR_ACK), 32'd1);
    bus.WR_REQ = 1'b0;
    if (turn) begin
      tick();
      chk({tag, " turn"}, strobes(), 32'b110);
    end
    tick();
    chk({tag, " wsetup"}, strobes(), 32'b111);
    chk({tag, " addr"}, 32'(bus.SRAM_ADDR), 32'(exp_addr));
    chk({tag, " data"}, 32'(sram_data), 32'(d));
    tick();
    chk({tag, " we0"}, strobes(), 32'b011);
    chk({tag, " data0"}, 32'(sram_data), 32'(d));
    tick();
    chk({tag, " we1"}, strobes(), 32'b011);
    tick();
    chk({tag, " idle"}, strobes(), 32'b110);
    chk({tag, " addr hold"}, 32'(bus.SRAM_ADDR), 32'(exp_addr));
  endtask

  task automatic do_read(input string tag, input logic [13:0] a, input logic [15:0] m,
                         input bit turn, input logic [15:0] exp_addr);
    rd_model = m; bus.RD_REQ = 1'b1; bus.RD_ADDR = a;
    tick();
    chk({tag, " ack"}, 32'(bus.RD_ACK), 32'd1);
    bus.RD_REQ = 1'b0;
    if (turn) begin
      tick();
      chk({tag, " turn"}, strobes(), 32'b110);
    end
    tick();
    chk({tag, " oe0"}, strobes(), 32'b100);
    chk({tag, " addr"}, 32'(bus.SRAM_ADDR), 32'(exp_addr));
    tick();
    chk({tag, " oe1"}, strobes(), 32'b100);
    chk({tag, " early valid"}, 32'(bus.RD_VALID), 32'd0);
    tick();
    chk({tag, " valid"}, 32'(bus.RD_VALID), 32'd1);
    chk({tag, " rdata"}, 32'(bus.RD_DATA), 32'(m));
    chk({tag, " oe off"}, strobes(), 32'b110);
    tick();
    chk({tag, " valid pulse"}, 32'(bus.RD_VALID), 32'd0);
    chk({tag, " rdata hold"}, 32'(bus.RD_DATA), 32'(m));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " strobes"}, strobes(), 32'b110);
    chk({tag, " acks"}, {30'd0, bus.WR_ACK, bus.RD_ACK}, 32'd0);
    chk({tag, " valid"}, 32'(bus.RD_VALID), 32'd0);
    chk({tag, " rdata"}, 32'(bus.RD_DATA), 32'd0);
    chk({tag, " addr"}, 32'(bus.SRAM_ADDR), 32'd0);
    chk({tag, " wr_buf"}, 32'(dut.wr_buf_q), 32'd0);
    chk({tag, " rd_buf"}, 32'(dut.rd_buf_q), 32'd3);
  endtask

  initial begin
    int rd_before, rd_after, wr_cyc, wr_cnt, overlap;
    bit seen_wr;

    rst_n = 1'b0; rd_model = '0;
    bus.MODE = 1'b1; bus.FRAME_WR = 1'b0; bus.FRAME_RD = 1'b0;
    bus.WR_REQ = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
    bus.RD_REQ = 1'b0; bus.RD_ADDR = '0;
    repeat (3) tick();
    chk_reset("reset");

    // Single write straight out of reset: no turnaround, bank 0
    rst_n = 1'b1;
    do_write("w1", 14'h0123, 16'hA5C3, 1'b0, 16'h0123);

    // Read after write needs a turnaround; read bank is 3 after reset
    do_read("r1", 14'h0042, 16'h5A5A, 1'b1, 16'hC042);
    do_read("r2", 14'h0100, 16'h1234, 1'b0, 16'hC100);

    // Both requesters held: four reads, starved write, then reads again
    rd_before = 0; rd_after = 0; wr_cyc = 0; wr_cnt = 0; overlap = 0; seen_wr = 1'b0;
    rd_model = 16'h0F0F;
    bus.RD_REQ = 1'b1; bus.RD_ADDR = 14'h0200;
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 14'h0300; bus.WR_DATA = 16'hCAFE;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.RD_ACK) begin
        if (!seen_wr) rd_before++;
        else if (rd_after == 0) rd_after = c;
      end
      if (bus.WR_ACK) begin
        wr_cnt++;
        if (!seen_wr) wr_cyc = c;
        seen_wr = 1'b1;
      end
      if (!bus.nSRAM_WE && !bus.nSRAM_OE) overlap++;
      if (dut.data_oe_q && !bus.nSRAM_OE) overlap++;
    end
    bus.RD_REQ = 1'b0; bus.WR_REQ = 1'b0;
    chk("starve reads first", 32'(rd_before), 32'd4);
    chk("starve write cycle", 32'(wr_cyc), 32'd9);
    chk("starve resume cycle", 32'(rd_after), 32'd13);
    chk("starve write count", 32'(wr_cnt), 32'd1);
    chk("strobe overlap", 32'(overlap), 32'd0);
    repeat (5) tick();
    chk("starve drained", strobes(), 32'b110);

    // Two capture frames then one video frame: write bank 2, read bank 1
    bus.FRAME_WR = 1'b1; tick(); bus.FRAME_WR = 1'b0; tick();
    bus.FRAME_WR = 1'b1; tick(); bus.FRAME_WR = 1'b0; tick();
    bus.FRAME_RD = 1'b1; tick(); bus.FRAME_RD = 1'b0; tick();
    do_write("bank w", 14'h0010, 16'hBEEF, 1'b1, 16'h8010);
    do_read("bank r", 14'h0020, 16'h1111, 1'b1, 16'h4020);
    bus.MODE = 1'b0;
    do_write("mode0 w", 14'h0011, 16'h2222, 1'b1, 16'h0011);
    do_read("mode0 r", 14'h0021, 16'h3333, 1'b1, 16'h0021);

    // Simultaneous frame pulses with write bank 2: write 3, read 1
    bus.FRAME_WR = 1'b1; bus.FRAME_RD = 1'b1; tick();
    bus.FRAME_WR = 1'b0; bus.FRAME_RD = 1'b0; bus.MODE = 1'b1;
    do_read("sim r", 14'h0000, 16'h4444, 1'b0, 16'h4000);
    do_write("sim w", 14'h0001, 16'h5555, 1'b1, 16'hC001);

    // Reset in the first WE-low cycle aborts the write
    bus.WR_REQ = 1'b1; bus.WR_ADDR = 14'h0002; bus.WR_DATA = 16'h6666;
    tick();
    chk("abort ack", 32'(bus.WR_ACK), 32'd1);
    bus.WR_REQ = 1'b0;
    tick();
    tick();
    chk("abort we0", strobes(), 32'b011);
    rst_n = 1'b0;
    tick();
    chk_reset("abort");
    rst_n = 1'b1;
    tick();
    chk("abort idle", strobes(), 32'b110);
    do_read("post r", 14'h0005, 16'h7777, 1'b0, 16'hC005);
    do_write("post w", 14'h0006, 16'h8888, 1'b1, 16'h0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
